// File: rtl/expr_recognizer.sv
// -----------------------------------------------------------------------------
// expr_recognizer
//   Byte-serial recogniser for ASCII arithmetic expressions: multi-digit
//   unsigned numbers, binary operators (+ * and optionally -) and optional
//   parentheses. One character is consumed on every clock where in_valid is
//   high and the byte belongs to the alphabet. Every other byte is ignored as
//   if it were absent. The registered flag out reports whether the prefix
//   consumed so far is a complete legal expression. err is sticky until clr.
//
// Ports
//   clk       in   1   clock, rising edge
//   clr       in   1   asynchronous active-high reset
//   in_valid  in   1   in carries a character to consume this cycle
//   in        in   8   ASCII character
//   out       out  1   consumed prefix is a complete legal expression
//   err       out  1   illegal sequence seen since clr (sticky)
//   depth     out  DW  currently open parentheses
//   ndig      out  NW  digits in the number being scanned
// -----------------------------------------------------------------------------
module expr_recognizer #(
  parameter int MAX_DIGITS  = 4,
  parameter int MAX_DEPTH   = 3,
  parameter int ALLOW_SUB   = 1,
  parameter int ALLOW_PAREN = 1,
  localparam int DW = $clog2(MAX_DEPTH + 1),
  localparam int NW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          out,
  output logic          err,
  output logic [DW-1:0] depth,
  output logic [NW-1:0] ndig
);

  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [NW-1:0] NMAX = NW'(MAX_DIGITS);

  state_t        state_p1, state_d;
  logic [DW-1:0] depth_p1, depth_d;
  logic [NW-1:0] ndig_p1, ndig_d;
  logic          lz_p1, lz_d;
  logic          out_d;

  logic          is_dig, is_op, is_lp, is_rp;
  logic          vld_p0;

  // Stage p0: classify the incoming byte; foreign bytes never qualify.
  always_comb begin
    is_dig = (in >= 8'h30) && (in <= 8'h39);
    is_op  = (in == 8'h2B) || (in == 8'h2A) || ((ALLOW_SUB != 0) && (in == 8'h2D));
    is_lp  = (ALLOW_PAREN != 0) && (in == 8'h28);
    is_rp  = (ALLOW_PAREN != 0) && (in == 8'h29);
    vld_p0 = in_valid && (is_dig || is_op || is_lp || is_rp);
  end

  always_comb begin
    state_d = state_p1;
    depth_d = depth_p1;
    ndig_d  = ndig_p1;
    lz_d    = lz_p1;
    if (vld_p0) begin
      unique case (state_p1)
        S_OPND: begin
          if (is_dig) begin
            state_d = S_NUM;
            ndig_d  = NW'(1);
            lz_d    = (in == 8'h30);
          end else if (is_lp && (depth_p1 < DMAX)) begin
            depth_d = depth_p1 + DW'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_dig) begin
            // A number may not grow past MAX_DIGITS, and "0" cannot be
            // followed by another digit (no leading zeros).
            if ((ndig_p1 == NMAX) || lz_p1) state_d = S_ERR;
            else                            ndig_d  = ndig_p1 + NW'(1);
          end else if (is_op) begin
            state_d = S_OPND;
            ndig_d  = '0;
            lz_d    = 1'b0;
          end else if (is_rp && (depth_p1 != '0)) begin
            state_d = S_CLOSE;
            depth_d = depth_p1 - DW'(1);
            ndig_d  = '0;
            lz_d    = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
        S_CLOSE: begin
          if (is_op) begin
            state_d = S_OPND;
          end else if (is_rp && (depth_p1 != '0)) begin
            depth_d = depth_p1 - DW'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        default: begin
          // S_ERR absorbs everything; depth/ndig keep their last values.
          state_d = S_ERR;
        end
      endcase
    end
    out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
  end

  // Stage p1: state and registered outputs update on the consuming edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_p1 <= S_OPND;
      depth_p1 <= '0;
      ndig_p1  <= '0;
      lz_p1    <= 1'b0;
      out      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_p1 <= state_d;
      depth_p1 <= depth_d;
      ndig_p1  <= ndig_d;
      lz_p1    <= lz_d;
      out      <= out_d;
      err      <= (state_d == S_ERR);
    end
  end

  assign depth = depth_p1;
  assign ndig  = ndig_p1;

endmodule
